// File: rtl/lcd_page_buffer.sv
// Reads one page-half of a row-major picture from ROM, transposes it into
// LCD column bytes, then hands the bytes out one per lcd_e falling edge.
module lcd_page_buffer #(
  parameter int PIC_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_request,
  input  logic [PIC_BITS+3:0]   addr,
  input  logic                  en,
  output logic                  data_ack,
  output logic [7:0]            data,
  output logic [PIC_BITS+9:0]   rom_addr,
  input  logic [7:0]            rom_data
);

  // state | meaning
  // IDLE  | waiting for a data_request rise
  // FILL  | reading 64 ROM bytes and transposing into the column buffer
  // READY | buffer valid, one column byte per en falling edge
  typedef enum logic [1:0] {IDLE, FILL, READY} state_t;

  state_t              state, state_nxt;
  logic                req_d, en_d;
  logic [PIC_BITS+3:0] addr_q;
  logic [5:0]          rd_idx, wr_idx, out_idx;
  logic                rd_done, wr_en, fill_done, consumed;
  logic [7:0]          pix_buf [64];
  logic                req_rise, en_fall;

  assign req_rise = data_request & ~req_d;
  assign en_fall  = en_d & ~en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    data_ack  = 1'b0;
    case (state)
      IDLE:    if (req_rise) state_nxt = FILL;
      FILL:    if (fill_done) state_nxt = READY;
      READY: begin
        data_ack = 1'b1;
        if (consumed) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d     <= 1'b0;
      en_d      <= 1'b0;
      addr_q    <= '0;
      rd_idx    <= '0;
      wr_idx    <= '0;
      out_idx   <= '0;
      rd_done   <= 1'b0;
      wr_en     <= 1'b0;
      fill_done <= 1'b0;
      consumed  <= 1'b0;
      rom_addr  <= '0;
      data      <= 8'h00;
    end else begin
      req_d <= data_request;
      en_d  <= en;
      case (state)
        IDLE: begin
          if (req_rise) begin
            addr_q    <= addr;
            rd_idx    <= '0;
            rd_done   <= 1'b0;
            wr_en     <= 1'b0;
            fill_done <= 1'b0;
            consumed  <= 1'b0;
          end
        end
        FILL: begin
          // {pic, page, row-in-page, half, byte} is pic*1024 + row*16 + half*8 + byte
          if (!rd_done) begin
            rom_addr <= {addr_q[PIC_BITS+3:4], addr_q[2:0], rd_idx[5:3],
                         addr_q[3], rd_idx[2:0]};
            rd_idx   <= rd_idx + 6'd1;
            rd_done  <= (rd_idx == 6'd63);
          end
          wr_en  <= ~rd_done;
          wr_idx <= rd_idx;
          if (wr_en && wr_idx == 6'd63) fill_done <= 1'b1;
          if (fill_done) begin
            out_idx  <= '0;
            data     <= pix_buf[0];
            consumed <= 1'b0;
          end
        end
        READY: begin
          if (en_fall) begin
            out_idx <= out_idx + 6'd1;
            if (out_idx == 6'd63) consumed <= 1'b1;
          end
          // after the last byte is taken, data keeps showing buf[63]
          if (!consumed) data <= pix_buf[out_idx];
        end
        default: ;
      endcase
    end
  end

  // ROM byte b of row r: leftmost pixel (bit 7) lands in column 8b, bit r of that column
  always_ff @(posedge clk) begin
    if (state == FILL && wr_en) begin
      for (int j = 0; j < 8; j++)
        pix_buf[{wr_idx[2:0], 3'(7 - j)}][wr_idx[5:3]] <= rom_data[j];
    end
  end

endmodule

// File: tb/tb_lcd_page_buffer.sv
// Self-checking bench for lcd_page_buffer: behavioural ROM, pixel-level
// transpose model feeding an expected-byte queue, per-scenario tasks.
module tb_lcd_page_buffer;
  localparam int PB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_request;
  logic [PB+3:0] addr;
  logic          en;
  logic          data_ack;
  logic [7:0]    data;
  logic [PB+9:0] rom_addr;
  logic [7:0]    rom_data;

  logic [7:0]    rom [8192];
  logic [7:0]    exp_q [$];
  logic [7:0]    got [64];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  // ROM output settles mid-cycle so it is ready at the next rising edge
  always @(negedge clk) rom_data <= rom[rom_addr];

  lcd_page_buffer #(.PIC_BITS(PB)) dut (
    .clk(clk), .rst(rst), .data_request(data_request), .addr(addr), .en(en),
    .data_ack(data_ack), .data(data), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] model_byte(int pic, int half, int page, int c);
    logic [7:0] r, v;
    int row, col;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      row  = 8 * page + k;
      col  = 64 * half + c;
      v    = rom[pic * 1024 + row * 16 + col / 8];
      r[k] = v[7 - (col % 8)];
    end
    return r;
  endfunction

  task automatic run_fill(input logic [6:0] a, input bit hold, input bit strobe,
                          output int first_a, output int last_a);
    int pic, half, page, n, i;
    logic [12:0] exp_a;
    pic = int'(a[6:4]); half = int'(a[3]); page = int'(a[2:0]);
    for (int c = 0; c < 64; c++) exp_q.push_back(model_byte(pic, half, page, c));
    first_a = -1; last_a = -1;
    @(negedge clk);
    data_request = 1'b1;
    addr = a;
    n = 0;
    while (data_ack !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1 && !hold) data_request = 1'b0;
      if (strobe && n >= 10 && n < 40) en = n[1];
      if (strobe && n == 40) en = 1'b0;
      if (n >= 2 && n <= 65) begin
        i = n - 2;
        exp_a = 13'(pic * 1024 + (8 * page + i / 8) * 16 + half * 8 + i % 8);
        if (n == 2) first_a = int'(rom_addr);
        if (n == 65) last_a = int'(rom_addr);
        checks++;
        if (rom_addr !== exp_a) begin
          errors++;
          $display("FAIL rom_addr idx %0d got %0d want %0d", i, rom_addr, exp_a);
        end
      end
    end
    checks++;
    if (n != 67) begin
      errors++;
      $display("FAIL ack_latency got %0d want 67", n);
    end
  endtask

  task automatic consume();
    logic [7:0] e;
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard empty at byte %0d", k);
        e = 8'hxx;
      end else begin
        e = exp_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL data byte %0d got %02h want %02h", k, data, e);
        end
      end
      checks++;
      if (data_ack !== 1'b1) begin
        errors++;
        $display("FAIL ack_hold byte %0d got %b want 1", k, data_ack);
      end
      got[k] = data;
      en = 1'b1;
      repeat (2) @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
    end
    checks++;
    if (data_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_drop got %b want 0", data_ack);
    end
    checks++;
    if (data !== got[63]) begin
      errors++;
      $display("FAIL data_hold got %02h want %02h", data, got[63]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; data_request = 1'b0; en = 1'b0; addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (data_ack !== 1'b0 || data !== 8'h00 || rom_addr !== '0) begin
      errors++;
      $display("FAIL reset_state got ack=%b data=%02h rom_addr=%0d want 0/00/0",
               data_ack, data, rom_addr);
    end
  endtask

  task automatic test_all_ones();
    int fa, la;
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 8; b++) rom[r * 16 + b] = 8'hFF;
    run_fill(7'h00, 1'b0, 1'b0, fa, la);
    consume();
    for (int k = 0; k < 64; k += 21) begin
      checks++;
      if (got[k] !== 8'hFF) begin
        errors++;
        $display("FAIL all_ones byte %0d got %02h want ff", k, got[k]);
      end
    end
    checks++;
    if (fa != 0 || la != 119) begin
      errors++;
      $display("FAIL all_ones_addr got %0d..%0d want 0..119", fa, la);
    end
  endtask

  task automatic test_reset_mid_fill();
    int fa, la;
    @(negedge clk);
    data_request = 1'b1;
    addr = 7'h00;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (n == 1) data_request = 1'b0;
    end
    checks++;
    if (rom_addr !== 13'd36 || data !== 8'hFF) begin
      errors++;
      $display("FAIL mid_fill got rom_addr=%0d data=%02h want 36/ff", rom_addr, data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (data_ack !== 1'b0 || data !== 8'h00 || rom_addr !== '0) begin
      errors++;
      $display("FAIL async_reset got ack=%b data=%02h rom_addr=%0d want 0/00/0",
               data_ack, data, rom_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    run_fill(7'h00, 1'b0, 1'b0, fa, la);
    consume();
  endtask

  task automatic test_transpose();
    int fa, la;
    for (int i = 128; i < 256; i++) rom[i] = 8'h00;
    rom[216] = 8'h02;
    run_fill({3'd0, 1'b1, 3'd1}, 1'b0, 1'b0, fa, la);
    consume();
    checks++;
    if (got[6] !== 8'h20) begin
      errors++;
      $display("FAIL transpose byte 6 got %02h want 20", got[6]);
    end
    checks++;
    if (got[5] !== 8'h00 || got[7] !== 8'h00 || got[0] !== 8'h00) begin
      errors++;
      $display("FAIL transpose neighbours got %02h %02h %02h want 00", got[5], got[7], got[0]);
    end
  endtask

  task automatic test_pic_select();
    int fa, la;
    run_fill({3'd5, 1'b0, 3'd7}, 1'b0, 1'b0, fa, la);
    checks++;
    if (fa != 6016 || la != 6135) begin
      errors++;
      $display("FAIL pic_select_addr got %0d..%0d want 6016..6135", fa, la);
    end
    consume();
  endtask

  task automatic test_ignored_events();
    int fa, la;
    logic [12:0] saved;
    run_fill({3'd2, 1'b1, 3'd4}, 1'b0, 1'b1, fa, la);
    saved = rom_addr;
    repeat (2) begin
      data_request = 1'b1;
      repeat (2) @(negedge clk);
      data_request = 1'b0;
      repeat (2) @(negedge clk);
    end
    checks++;
    if (rom_addr !== saved || data_ack !== 1'b1) begin
      errors++;
      $display("FAIL req_in_ready got rom_addr=%0d ack=%b want %0d/1", rom_addr, data_ack, saved);
    end
    consume();
  endtask

  task automatic test_hold_high();
    int fa, la;
    logic [12:0] saved;
    run_fill({3'd3, 1'b0, 3'd2}, 1'b1, 1'b0, fa, la);
    consume();
    saved = rom_addr;
    repeat (80) @(negedge clk);
    checks++;
    if (data_ack !== 1'b0 || rom_addr !== saved) begin
      errors++;
      $display("FAIL hold_high got ack=%b rom_addr=%0d want 0/%0d", data_ack, rom_addr, saved);
    end
    data_request = 1'b0;
    @(negedge clk);
    run_fill({3'd3, 1'b0, 3'd3}, 1'b0, 1'b0, fa, la);
    consume();
  endtask

  task automatic test_back_to_back();
    int fa, la;
    run_fill({3'd7, 1'b1, 3'd6}, 1'b0, 1'b0, fa, la);
    consume();
    run_fill({3'd7, 1'b1, 3'd7}, 1'b0, 1'b0, fa, la);
    consume();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);
    test_reset();
    test_all_ones();
    test_reset_mid_fill();
    test_transpose();
    test_pic_select();
    test_ignored_events();
    test_hold_high();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_page_buffer.md
# lcd_page_buffer

Data re-arrangement buffer between the picture ROM and the LCD controller in the 128x64 two-half graphic LCD path. On a request from the LCD controller it reads one page-half (8 rows x 64 pixels) of a row-major monochrome picture from a synchronous ROM. It transposes the data into 64 column bytes in LCD page format, then hands the bytes out one per LCD enable strobe. It runs on the divided LCD clock, in the same domain as the LCD controller.

## Interface
- PIC_BITS, 3, picture-select width; `addr` is PIC_BITS+4 bits, `rom_addr` is PIC_BITS+10 bits
- clk  in  1  LCD-domain clock (divided 50 kHz clock)
- rst  in  1  reset, asynchronous, active-high
- data_request  in  1  request from LCD controller; a 0->1 transition starts a transfer
- addr  in  PIC_BITS+4  {pic, half, page[2:0]}, sampled on the request rise
- en  in  1  LCD enable (lcd_e); each falling edge consumes one byte
- data_ack  out  1  high while the 64-byte buffer is valid and not fully consumed
- data  out  8  current column byte
- rom_addr  out  PIC_BITS+10  byte address into the picture ROM
- rom_data  in  8  ROM read data, valid one clk after rom_addr

## Operation
- ROM image layout: each picture is 1024 bytes, 16 bytes per row, 64 rows. Byte address = pic*1024 + row*16 + byte. Bit 7 is the leftmost pixel.
- Output layout: column byte c (0..63) of page p, half h. Bit k = pixel(row 8p+k, col 64h+c). Bit 0 is the top row.
- States: IDLE, FILL, READY.
- IDLE:
  - `req_d` is `data_request` registered. A rise is `data_request & ~req_d`.
  - On a rise: latch `addr`, clear the read counter, go to FILL.
- FILL:
  - Read index i runs 0..63 with row r = i[5:3] and byte b = i[2:0].
  - rom_addr = pic*1024 + (8p+r)*16 + h*8 + b.
  - When data for index i returns, bit j of rom_data is written to buf[8b+(7-j)] bit r. Eight buffer bits are written per cycle.
  - After the 64th write, clear the output index, assert data_ack, go to READY.
- READY:
  - `data` = buf[idx].
  - A falling edge of en (en_d & ~en) increments idx, and `data` updates on the following edge.
  - On the 64th falling edge, data_ack drops and the block returns to IDLE.
- Ignored events:
  - en falling edges outside READY.
  - Request rises in FILL or READY. A new transfer needs data_request to be low for at least one clk in IDLE, then rise.
- Arithmetic:
  - Counters are 6 bits. The wrap 63->0 marks completion and is not an error.
  - rom_addr is computed with no overflow within PIC_BITS+10 bits.
- rst asserted at any time:
  - State goes to IDLE.
  - data_ack=0, data=8'h00, rom_addr=0.
  - All counters, req_d and en_d are cleared.
  - Buffer contents are don't-care.
  - A transfer in progress is abandoned. After reset the next request rise starts a fresh fill.

## Timing
- Cycle 0 is the clk edge that samples the request rise. The first rom_addr is driven after edge 1.
- rom_addr for index i is valid during cycle i+1. rom_data for index i is written at edge i+2.
- The last write is at edge 65. data_ack goes high after edge 66, giving a fixed latency of 66 clk from request sample to ack.
- data = buf[0] is valid no later than the cycle data_ack rises.
- A byte is consumed when en is sampled high on one edge and low on the next.
- data changes one clk after the edge that detects the fall. It stays stable through the entire next en high phase, provided en low lasts at least 2 clk.
- data_ack deasserts one clk after the edge detecting the 64th en fall. data holds buf[63] until the next fill.
- Throughput: one transfer per 66 + 64*(en period) clk. The fill never overlaps the output phase.

## Test plan
- Reset: assert rst mid-FILL (index 20) -> data_ack=0, data=00, rom_addr=0 immediately. Then request addr={0,0,000} -> data_ack rises at cycle 66.
- All-ones rows: picture 0, rows 0..7 cols 0..63 = FF, request page 0 half 0 -> 64 bytes all FF. Reads hit ROM addresses 0..7, 16..23, ..., 112..119.
- Transpose check: the ROM has a single pixel set at row 13, col 70 (byte 13*16+8=216, value 8'h02). Request page 1 half 1 -> byte 6 = 8'h20, all other bytes 00. data_ack drops after the 64th en fall.
- Picture select: request pic 5 page 7 half 0 -> first rom_addr = 5*1024+56*16 = 6016, last = 6016+7*16+7 = 6135.
- Ignored events:
  - En strobes during FILL -> no change to data or idx.
  - Request toggled during READY -> no refetch; rom_addr holds.
  - data_request held high through completion, then a second transfer -> no second transfer until it goes low and rises again.
- Back-to-back transfers: request the next page immediately after data_ack falls -> data_ack rises again 66 clk after the new rise is sampled, with correct data.
